// File: rtl/decrypt_pipe_if.sv
// Byte-stream bundle for the receive-side decrypt pipeline.
// The master drives ciphertext and per-byte config; the slave returns plaintext.
interface decrypt_pipe_if;
   logic       en;
   logic [7:0] din;
   logic [7:0] k1;
   logic [7:0] k2;
   logic [7:0] k3;
   logic [2:0] rot_freq;
   logic       shift_en;
   logic [3:0] shift_amt;
   logic       mode;
   logic [7:0] dout;
   logic       en_out;

   modport master (
      output en, din, k1, k2, k3,
      output rot_freq, shift_en, shift_amt, mode,
      input  dout, en_out
   );

   modport slave (
      input  en, din, k1, k2, k3,
      input  rot_freq, shift_en, shift_amt, mode,
      output dout, en_out
   );
endinterface

// File: rtl/decrypt_pipe_unit.sv
// Three-stage decrypt: rotating-key XOR, alpha classify, inverse shift mod 26.
// Config rides with each byte so mid-stream changes only affect later bytes.
module decrypt_pipe_unit (
   input logic          clk,
   input logic          rst,
   decrypt_pipe_if.slave bus
);

   logic [1:0] key_idx;
   logic [2:0] byte_cnt;
   logic [7:0] key;

   // stage 1 registers
   logic       v1;
   logic [7:0] x1;
   logic       mode1;
   logic       shen1;
   logic [3:0] amt1;

   // stage 2 registers
   logic       v2;
   logic [7:0] x2;
   logic       up2;
   logic       lo2;
   logic       mode2;
   logic       shen2;
   logic [3:0] amt2;

   logic             up1;
   logic             lo1;
   logic [7:0]       base;
   logic signed [5:0] d;
   logic [7:0]       res;

   always_comb begin
      key = bus.k1;
      if (bus.rot_freq != 3'd0) begin
         unique case (1'b1)
            (key_idx == 2'd1): key = bus.k2;
            (key_idx == 2'd2): key = bus.k3;
            default:           key = bus.k1;
         endcase
      end
   end

   // Terminal count uses >= so a mid-stream rot_freq decrease cannot strand byte_cnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_idx  <= 2'd0;
         byte_cnt <= 3'd0;
      end else if (bus.en && bus.mode) begin
         if (bus.rot_freq == 3'd0) begin
            key_idx  <= 2'd0;
            byte_cnt <= 3'd0;
         end else if (byte_cnt >= bus.rot_freq - 3'd1) begin
            byte_cnt <= 3'd0;
            key_idx  <= (key_idx == 2'd2) ? 2'd0 : key_idx + 2'd1;
         end else begin
            byte_cnt <= byte_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1    <= 1'b0;
         x1    <= 8'h00;
         mode1 <= 1'b0;
         shen1 <= 1'b0;
         amt1  <= 4'd0;
      end else begin
         v1 <= bus.en;
         if (bus.en) begin
            x1    <= bus.mode ? (bus.din ^ key) : bus.din;
            mode1 <= bus.mode;
            shen1 <= bus.shift_en;
            amt1  <= bus.shift_amt;
         end
      end
   end

   assign up1 = (x1 >= 8'h41) && (x1 <= 8'h5A);
   assign lo1 = (x1 >= 8'h61) && (x1 <= 8'h7A);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2    <= 1'b0;
         x2    <= 8'h00;
         up2   <= 1'b0;
         lo2   <= 1'b0;
         mode2 <= 1'b0;
         shen2 <= 1'b0;
         amt2  <= 4'd0;
      end else begin
         v2 <= v1;
         if (v1) begin
            x2    <= x1;
            up2   <= up1;
            lo2   <= lo1;
            mode2 <= mode1;
            shen2 <= shen1;
            amt2  <= amt1;
         end
      end
   end

   // Offset in 0..25 minus shift in 0..15 fits 6-bit signed; one +26 fixes it.
   always_comb begin
      base = up2 ? 8'h41 : 8'h61;
      d    = $signed(6'(x2 - base)) - $signed({2'b00, amt2});
      if (d < 0) begin
         d = d + 6'sd26;
      end
      res = x2;
      if (mode2 && shen2 && (up2 || lo2)) begin
         res = base + {2'b00, 6'(d)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.dout   <= 8'h00;
         bus.en_out <= 1'b0;
      end else begin
         bus.en_out <= v2;
         if (v2) begin
            bus.dout <= res;
         end
      end
   end

endmodule

// File: tb/tb_decrypt_pipe_unit.sv
// Directed bench for decrypt_pipe_unit: vector table plus rotation,
// bypass-key and mid-stream reset sequences.
module tb_decrypt_pipe_unit;

   logic clk;
   logic rst;
   int   ntests;
   int   nfail;

   decrypt_pipe_if bus ();

   decrypt_pipe_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       mode;
      logic       sh;
      logic [3:0] amt;
      logic [7:0] k1;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [14];

   logic       cap;
   int         ccnt;
   logic [7:0] q  [$];
   int         cq [$];

   always @(negedge clk) begin
      ccnt <= ccnt + 1;
      if (cap && bus.en_out) begin
         q.push_back(bus.dout);
         cq.push_back(ccnt);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send_one(input string nm, input vec_t v);
      bus.mode      = v.mode;
      bus.shift_en  = v.sh;
      bus.shift_amt = v.amt;
      bus.k1        = v.k1;
      bus.din       = v.din;
      bus.en        = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      @(negedge clk);
      chk({nm, " early"}, {7'd0, bus.en_out}, 8'd0);
      @(negedge clk);
      chk({nm, " valid"}, {7'd0, bus.en_out}, 8'd1);
      chk({nm, " dout"}, bus.dout, v.exp);
      @(negedge clk);
      chk({nm, " after"}, {7'd0, bus.en_out}, 8'd0);
   endtask

   task automatic pulse_rst();
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_rot(input int gap_at, input int exp_gap);
      logic [7:0] expq [8];
      expq = '{8'h11, 8'h11, 8'hFF, 8'hFF, 8'hDE, 8'hDE, 8'h11, 8'h11};
      q.delete();
      cq.delete();
      cap = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.en  = 1'b1;
         bus.din = 8'h00;
         @(negedge clk);
         if (i == gap_at) begin
            bus.en = 1'b0;
            @(negedge clk);
         end
      end
      bus.en = 1'b0;
      repeat (6) @(negedge clk);
      cap = 1'b0;
      chk("rot count", 8'(q.size()), 8'd8);
      if (q.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("rot byte%0d", i), q[i], expq[i]);
         end
         chk("rot gap", 8'(cq[7] - cq[0] - 7), 8'(exp_gap));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      ntests = 0;
      nfail  = 0;
      cap    = 1'b0;
      ccnt   = 0;
      rst    = 1'b0;
      bus.en        = 1'b0;
      bus.din       = 8'h00;
      bus.k1        = 8'h00;
      bus.k2        = 8'h00;
      bus.k3        = 8'h00;
      bus.rot_freq  = 3'd0;
      bus.shift_en  = 1'b0;
      bus.shift_amt = 4'd0;
      bus.mode      = 1'b0;

      //            mode sh  amt    k1     din    exp
      vecs[0]  = '{1'b1, 1'b1, 4'd1,  8'h11, 8'h53, 8'h41};
      vecs[1]  = '{1'b1, 1'b1, 4'd3,  8'h11, 8'h70, 8'h78};
      vecs[2]  = '{1'b1, 1'b1, 4'd3,  8'h11, 8'h50, 8'h58};
      vecs[3]  = '{1'b1, 1'b1, 4'd0,  8'h11, 8'h53, 8'h42};
      vecs[4]  = '{1'b1, 1'b1, 4'd5,  8'h00, 8'h5B, 8'h5B};
      vecs[5]  = '{1'b0, 1'b1, 4'd1,  8'h11, 8'h53, 8'h53};
      vecs[6]  = '{1'b1, 1'b0, 4'd1,  8'h11, 8'h53, 8'h42};
      vecs[7]  = '{1'b1, 1'b1, 4'd15, 8'h00, 8'h7A, 8'h6B};
      vecs[8]  = '{1'b1, 1'b1, 4'd15, 8'h00, 8'h5A, 8'h4B};
      vecs[9]  = '{1'b1, 1'b1, 4'd1,  8'h00, 8'h40, 8'h40};
      vecs[10] = '{1'b1, 1'b1, 4'd1,  8'h00, 8'h60, 8'h60};
      vecs[11] = '{1'b1, 1'b1, 4'd1,  8'h00, 8'h7B, 8'h7B};
      vecs[12] = '{1'b1, 1'b1, 4'd1,  8'hFF, 8'h9E, 8'h7A};
      vecs[13] = '{1'b1, 1'b1, 4'd15, 8'h00, 8'h41, 8'h4C};

      #1 rst = 1'b1;
      #1;
      chk("reset dout", bus.dout, 8'h00);
      chk("reset en_out", {7'd0, bus.en_out}, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         send_one($sformatf("vec%0d", i), vecs[i]);
      end

      // key rotation, back-to-back then with a bubble
      bus.mode     = 1'b1;
      bus.shift_en = 1'b0;
      bus.rot_freq = 3'd2;
      bus.k1       = 8'h11;
      bus.k2       = 8'hFF;
      bus.k3       = 8'hDE;
      pulse_rst();
      run_rot(-1, 0);
      pulse_rst();
      run_rot(2, 1);

      // bypass byte must not advance the key
      bus.rot_freq = 3'd1;
      bus.k2       = 8'h22;
      pulse_rst();
      v = '{1'b0, 1'b0, 4'd0, 8'h11, 8'h53, 8'h53};
      send_one("bypass", v);
      v = '{1'b1, 1'b0, 4'd0, 8'h11, 8'h00, 8'h11};
      send_one("post-bypass k1", v);
      v = '{1'b1, 1'b0, 4'd0, 8'h11, 8'h00, 8'h22};
      send_one("post-bypass k2", v);

      // reset mid-stream
      bus.k3       = 8'h33;
      bus.mode     = 1'b1;
      bus.shift_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.en  = 1'b1;
         bus.din = 8'h00;
         @(posedge clk);
      end
      #1;
      chk("midstream valid", {7'd0, bus.en_out}, 8'd1);
      #1 rst = 1'b1;
      bus.en = 1'b0;
      #1;
      chk("midrst dout", bus.dout, 8'h00);
      chk("midrst en_out", {7'd0, bus.en_out}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("no stale %0d", i), {7'd0, bus.en_out}, 8'd0);
      end
      v = '{1'b1, 1'b0, 4'd0, 8'h11, 8'h00, 8'h11};
      send_one("post-reset k1", v);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/decrypt_pipe_unit.md
# decrypt_pipe_unit

Three-stage decrypt pipeline that inverts the encrypt path's shift-then-XOR transform. Each byte is XOR-descrambled with a rotating key (k1/k2/k3), classified as upper-case, lower-case or non-alpha, and then shifted back modulo 26. The block sits at the receive end of the cipher link. It takes ciphertext bytes with a valid strobe and per-byte configuration, and delivers plaintext three cycles later with its own valid strobe.

## Interface
- No parameters. Data width is fixed at 8 bits and the shift range at 4 bits.
- clk  in  1  single clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  input byte valid; din and configuration are sampled only when en=1.
- din  in  8  ciphertext byte.
- k1, k2, k3  in  8 each  XOR keys, selected round-robin.
- rot_freq  in  3  key rotation period in bytes; 0 means no rotation (k1 only).
- shift_en  in  1  1 = apply the inverse alpha shift; 0 = skip the shift stage.
- shift_amt  in  4  shift distance, 0..15.
- mode  in  1  1 = decrypt; 0 = bypass (data piped through unchanged).
- dout  out  8  plaintext byte.
- en_out  out  1  dout valid.

## Operation
- **Per-byte configuration.** mode, shift_en and shift_amt are captured with each byte at stage 1 and travel down the pipeline alongside it. Changing them mid-stream affects only later bytes.
- **Key select.**
  - key_idx is 2 bits with values 0→k1, 1→k2, 2→k3, then wraps back to 0.
  - byte_cnt is 3 bits.
  - Both registers change only on a cycle with en=1 and mode=1.
  - rot_freq=0: key_idx stays at 0 and byte_cnt is unused.
  - rot_freq≠0: the current byte uses key_idx. Then byte_cnt increments. When byte_cnt reaches rot_freq−1, byte_cnt clears to 0 and key_idx advances, wrapping 2→0.
  - Each key therefore covers rot_freq consecutive bytes.
- **Stage 1 (XOR).** x = din ^ key[key_idx] when mode=1; x = din when mode=0.
- **Stage 2 (classify).**
  - upper = (0x41 ≤ x ≤ 0x5A).
  - lower = (0x61 ≤ x ≤ 0x7A).
  - upper and lower are mutually exclusive.
  - x, the flags and the carried configuration are all registered.
- **Stage 3 (unshift).** Applies only when mode=1, shift_en=1 and (upper or lower). With base = 0x41 for upper or 0x61 for lower:
  - d = (x − base) − shift_amt, computed in 6-bit signed arithmetic.
  - If d < 0, then d = d + 26.
  - out = base + d.
  - A single conditional +26 is sufficient because shift_amt ≤ 15 < 26.
  - In every other case, out = x.
- **Bubbles.** An en=0 input creates a bubble that propagates as en_out=0. dout holds its last value during a bubble.
- **Bypass.** mode=0 bytes do not advance key_idx or byte_cnt.

## Timing
- **Latency.** A byte sampled on rising edge N appears on dout with en_out=1 after edge N+2, i.e. three registered stages. One byte per cycle is sustained with no stall and no backpressure.
- **Reset.** Asserting rst clears immediately, independent of clk:
  - dout=0x00 and en_out=0;
  - all stage valid bits are 0;
  - key_idx=0 and byte_cnt=0.
- **Reset mid-operation.** In-flight bytes are discarded; none of them is ever presented with en_out=1. After deassertion, the first accepted byte uses k1.
- **Reset release.** rst is deasserted away from the clock edge. The first en sample happens at the first rising edge after deassertion.
- **Simultaneous events.** On the edge where rot_freq terminal count and en coincide, the current byte uses the old key_idx and the next byte uses the new one.

## Test plan
- **Basic decrypt.** mode=1, shift_en=1, shift_amt=1, rot_freq=0, k1=0x11, din=0x53 with a single-cycle en → dout=0x41 and en_out=1 exactly 3 edges later; en_out=0 on the following cycle.
- **Wrap-around.** k1=0x11, shift_amt=3, din=0x70 (x=0x61 'a') → dout=0x78 'x'. Also din=0x50 (x=0x41 'A') → dout=0x58 'X'. Also shift_amt=0 → dout=x.
- **Key rotation.** mode=1, shift_en=0, rot_freq=2, k1=0x11, k2=0xFF, k3=0xDE; eight back-to-back bytes of din=0x00 → dout sequence 0x11,0x11,0xFF,0xFF,0xDE,0xDE,0x11,0x11. Repeat with one en=0 gap inserted after byte 3 → the same sequence, with one en_out=0 bubble.
- **Non-alpha and bypass.**
  - k1=0x00, shift_en=1, shift_amt=5, din=0x5B → dout=0x5B.
  - mode=0, din=0x53 → dout=0x53, and key_idx is unchanged. Check this by sending a following mode=1 byte with rot_freq=1: it must still use k1.
- **Reset mid-stream.** Stream 0x53 for 5 cycles, assert rst asynchronously between edges → dout=0x00 and en_out=0 immediately. After release, no stale byte is output, and the next byte decrypts with k1.
